// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack port
// and the valid/ready instruction port toward ID.
interface if_fetch_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRdata;
  logic        InsValid;
  logic        IdReady;
  logic [31:0] Ins;
  logic [31:0] nextPC;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemRdata,
    output InsValid,
    input  IdReady,
    output Ins,
    output nextPC
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemRdata,
    input  InsValid,
    output IdReady,
    input  Ins,
    input  nextPC
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request
// at a time and queues {PC+4, instruction} entries for ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Redirect,
  input  logic [31:0] newPC,
  if_fetch_if.master  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [63:0]   r_mem [DEPTH];

  logic          w_valid;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_room;
  logic [31:0]   w_pc4;
  logic [31:0]   w_tgt;
  logic          w_unused;

  assign w_unused  = ^newPC[1:0];
  assign w_tgt     = {newPC[31:2], 2'b00};
  assign w_pc4     = r_pc + 32'd4;
  assign w_valid   = (r_cnt != '0);
  assign w_ack     = r_req & bus.IMemAck;
  assign w_push    = w_ack & (r_state == S_BUSY);
  assign w_pop     = w_valid & bus.IdReady;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_room    = (w_cnt_nxt < CW'(DEPTH));

  assign bus.IMemReq  = r_req;
  assign bus.IMemAddr = r_addr;
  assign bus.InsValid = w_valid;
  assign bus.Ins      = w_valid ? r_mem[r_rp][31:0]  : '0;
  assign bus.nextPC   = w_valid ? r_mem[r_rp][63:32] : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else if (Redirect) begin
      r_pc  <= w_tgt;
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_BUSY;
          r_req   <= 1'b1;
          r_addr  <= w_tgt;
        end
        S_BUSY, S_KILL: begin
          // an unacked request must finish before the new target goes out
          if (w_ack) begin
            r_state <= S_BUSY;
            r_addr  <= w_tgt;
          end else begin
            r_state <= S_KILL;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_room) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_BUSY: begin
          if (w_ack) begin
            r_pc <= w_pc4;
            if (w_room) begin
              r_addr <= w_pc4;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        S_KILL: begin
          if (w_ack) begin
            r_state <= S_BUSY;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push && !Redirect) begin
      r_mem[r_wp] <= {w_pc4, bus.IMemRdata};
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table plus
// hand sequences, with a scoreboard of fetched entries.
module tb_if_fetch;

  logic        CLK;
  logic        RST;
  logic        Redirect;
  logic [31:0] newPC;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Redirect(Redirect),
    .newPC   (newPC),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic [31:0] tg;
    logic        ak;
    logic        ry;
    logic        bad;
    logic        xq;
    logic [31:0] xa;
    logic        xv;
    logic [31:0] xn;
  } vec_t;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] ins;
  } ent_t;

  int          n_chk;
  int          n_fail;
  ent_t        sb [$];
  logic [31:0] exp_pc;
  logic        m_stale;
  vec_t        tv [20];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc  = 32'h0;
    m_stale = 1'b0;
  endtask

  task automatic step(input logic rd, input logic [31:0] tg,
                      input logic ak, input logic ry, input logic bad);
    ent_t        e;
    logic        live;
    logic [31:0] dat;
    dat           = bad ? 32'hDEAD_BEEF : mem(bus.IMemAddr);
    Redirect      = rd;
    newPC         = tg;
    bus.IMemAck   = ak;
    bus.IdReady   = ry;
    bus.IMemRdata = dat;
    chk("valid", 32'(bus.InsValid), 32'(sb.size() != 0));
    if (!bus.InsValid) begin
      chk("ins_zero", bus.Ins, 32'h0);
      chk("npc_zero", bus.nextPC, 32'h0);
    end
    if (bus.InsValid && ry && !rd && sb.size() != 0) begin
      e = sb.pop_front();
      chk("ins", bus.Ins, e.ins);
      chk("npc", bus.nextPC, e.npc);
    end
    live = ak && bus.IMemReq;
    if (live && !m_stale && !rd) begin
      chk("addr", bus.IMemAddr, exp_pc);
      e.npc = exp_pc + 32'd4;
      e.ins = dat;
      sb.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (live) m_stale = 1'b0;
    if (rd) begin
      sb.delete();
      exp_pc = {tg[31:2], 2'b00};
      if (bus.IMemReq && !ak) m_stale = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req"}, 32'(bus.IMemReq), 32'h0);
    chk({nm, "_addr"}, bus.IMemAddr, 32'h0);
    chk({nm, "_valid"}, 32'(bus.InsValid), 32'h0);
    chk({nm, "_ins"}, bus.Ins, 32'h0);
    chk({nm, "_npc"}, bus.nextPC, 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tv[0]  = '{0, 32'h0,         0, 0, 0, 1, 32'h0,        0, 32'h0};
    tv[1]  = '{0, 32'h0,         1, 0, 0, 1, 32'h4,        1, 32'h4};
    tv[2]  = '{0, 32'h0,         1, 0, 0, 0, 32'h0,        1, 32'h4};
    tv[3]  = '{0, 32'h0,         1, 0, 0, 0, 32'h0,        1, 32'h4};
    tv[4]  = '{0, 32'h0,         0, 1, 0, 1, 32'h8,        1, 32'h8};
    tv[5]  = '{0, 32'h0,         0, 1, 0, 1, 32'h8,        0, 32'h0};
    tv[6]  = '{0, 32'h0,         1, 1, 0, 1, 32'hC,        1, 32'hC};
    tv[7]  = '{0, 32'h0,         1, 0, 0, 0, 32'h0,        1, 32'hC};
    tv[8]  = '{1, 32'h43,        0, 1, 0, 1, 32'h40,       0, 32'h0};
    tv[9]  = '{0, 32'h0,         0, 1, 0, 1, 32'h40,       0, 32'h0};
    tv[10] = '{0, 32'h0,         1, 0, 0, 1, 32'h44,       1, 32'h44};
    tv[11] = '{1, 32'h200,       1, 0, 0, 1, 32'h200,      0, 32'h0};
    tv[12] = '{1, 32'h100,       0, 0, 0, 1, 32'h200,      0, 32'h0};
    tv[13] = '{1, 32'h300,       0, 0, 0, 1, 32'h200,      0, 32'h0};
    tv[14] = '{0, 32'h0,         1, 1, 1, 1, 32'h300,      0, 32'h0};
    tv[15] = '{0, 32'h0,         1, 1, 0, 1, 32'h304,      1, 32'h304};
    tv[16] = '{1, 32'hFFFF_FFFE, 0, 0, 0, 1, 32'h304,      0, 32'h0};
    tv[17] = '{0, 32'h0,         1, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0};
    tv[18] = '{0, 32'h0,         1, 0, 0, 1, 32'h0,        1, 32'h0};
    tv[19] = '{0, 32'h0,         0, 1, 0, 1, 32'h0,        0, 32'h0};

    RST           = 1'b0;
    Redirect      = 1'b0;
    newPC         = '0;
    bus.IMemAck   = 1'b0;
    bus.IMemRdata = '0;
    bus.IdReady   = 1'b0;
    model_reset();
    #2;
    chk_zero("rst0");
    #10;
    RST = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tv[i].rd, tv[i].tg, tv[i].ak, tv[i].ry, tv[i].bad);
      chk($sformatf("v%0d_req", i), 32'(bus.IMemReq), 32'(tv[i].xq));
      if (tv[i].xq)
        chk($sformatf("v%0d_addr", i), bus.IMemAddr, tv[i].xa);
      chk($sformatf("v%0d_valid", i), 32'(bus.InsValid), 32'(tv[i].xv));
      chk($sformatf("v%0d_npc", i), bus.nextPC, tv[i].xn);
    end

    // async reset with a request live, then stray acks while held
    #3;
    RST = 1'b0;
    #1;
    chk_zero("rst1");
    model_reset();
    bus.IMemAck = 1'b1;
    @(posedge CLK);
    #1;
    chk_zero("rst1_hold");
    #2;
    RST = 1'b1;
    step(0, 32'h0, 1, 1, 0);
    chk("first_req", 32'(bus.IMemReq), 32'h1);
    chk("first_addr", bus.IMemAddr, 32'h0);
    chk("first_valid", 32'(bus.InsValid), 32'h0);

    // streaming: one instruction per cycle
    for (int k = 0; k < 12; k++) begin
      step(0, 32'h0, 1, 1, 0);
      chk("strm_req", 32'(bus.IMemReq), 32'h1);
      chk("strm_valid", 32'(bus.InsValid), 32'h1);
      chk("strm_addr", bus.IMemAddr, 32'(4 * (k + 1)));
      chk("strm_npc", bus.nextPC, 32'(4 * (k + 1)));
    end

    #3;
    RST = 1'b0;
    #1;
    chk_zero("rst2");
    model_reset();
    bus.IMemAck = 1'b0;
    @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the MIPS pipeline, directly upstream of the ID stage. It owns the program counter, drives a request/acknowledge instruction-memory port, buffers fetched words in a small FIFO, and presents `Ins`/`nextPC` to ID under a valid/ready handshake. Redirects from EX (jumps, taken branches, `JR`) flush the buffer and restart fetch at `newPC`, discarding any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.

- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Redirect`  in  1  EX requests PC change this cycle.
- `newPC`  in  32  redirect target; bits [1:0] ignored (treated as 00).
- `IMemReq`  out  1  fetch request, registered.
- `IMemAddr`  out  32  fetch word address, registered, bits [1:0]=00.
- `IMemAck`  in  1  memory accepts the request; `IMemRdata` valid in the same cycle.
- `IMemRdata`  in  32  instruction word.
- `InsValid`  out  1  FIFO head valid for ID.
- `IdReady`  in  1  ID consumes head this cycle.
- `Ins`  out  32  head instruction; 0 when `InsValid`=0.
- `nextPC`  out  32  head PC+4 (mod 2^32); 0 when `InsValid`=0.

## Operation
- Entry = {PC+4, instruction}. Push on accepted response, pop when `InsValid && IdReady`.
- Fetch PC `pc`: address of the next request to issue; +4 per accepted non-killed response, wraps at 2^32.
- Memory handshake: once `IMemReq`=1, `IMemReq` and `IMemAddr` stay stable until the cycle `IMemAck`=1. At most one outstanding request. `IMemAck` with `IMemReq`=0 is ignored.
- States:
  - IDLE: no request. Go to BUSY (Req=1, Addr=`pc`) when `count_next < DEPTH`.
  - BUSY: request live. On ack: push, `pc+=4`; stay BUSY with new address if `count_next < DEPTH`, else IDLE.
  - KILL: request live, response stale. On ack: drop data, go to BUSY at `pc` (FIFO is empty).
- `count_next` = count after this edge's push/pop.
- Redirect (highest priority, at the edge where `Redirect`=1):
  - FIFO cleared (count=0); any simultaneous pop or push is discarded.
  - `pc` ← `{newPC[31:2],2'b00}`.
  - IDLE → BUSY at the new pc.
  - BUSY, no ack → KILL; address unchanged.
  - BUSY with ack → data dropped, BUSY at the new pc.
  - KILL, no ack → KILL, `pc` takes the latest target.
  - KILL with ack → BUSY at the new pc.
- Full FIFO: no new request issued. Pop and push in the same cycle on a full FIFO is legal only when a request was already outstanding; count is unchanged.
- Empty FIFO: `InsValid`=0 and `IdReady` is ignored.

## Timing
- Reset (async assert, any state): `pc`=`RESET_PC`, state IDLE, `IMemReq`=0, `IMemAddr`=0, count=0, `InsValid`=0, `Ins`=0, `nextPC`=0. In-flight responses are forgotten, and a later stray ack is ignored because `IMemReq`=0.
- First rising edge after `RST` deasserts: `IMemReq`=1, `IMemAddr`=`RESET_PC`.
- Fetch-to-ID latency: ack at edge N, so `InsValid`=1 after edge N (same cycle the next address appears).
- Throughput: 1 instruction/cycle with ack every cycle and `IdReady`=1.
- Redirect-to-request: next address = target after the redirect edge if no request is pending, otherwise 1 cycle after the stale ack.
- `InsValid`, `Ins`, `nextPC` derive from registered FIFO state only. There is no combinational path from `IMemRdata`, `Redirect` or `IdReady` to these outputs.

## Test plan
- Reset/streaming: `RESET_PC`=0, ack every cycle, `IdReady`=1 → addresses 0,4,8,… on consecutive cycles; ID sees `Ins`=mem[0] with `nextPC`=4, then `nextPC`=8, …; assert `RST` low mid-stream → all outputs 0 immediately.
- Backpressure: `IdReady`=0 → after 2 acks `IMemReq` drops, `InsValid`=1 holds `nextPC`=4; raise `IdReady` → entries drain in order and fetch resumes at 8.
- Redirect with no request pending: FIFO full, `Redirect`=1, `newPC`=32'h0000_0043 → FIFO empties, next `IMemAddr`=32'h40.
- Redirect with request in flight: Req at 0x10, no ack, redirect to 0x100 → Addr holds 0x10; ack with 32'hDEADBEEF is dropped (never seen on `InsValid`); next Addr=0x100.
- Coincident events: redirect and ack in the same cycle, and redirect and pop in the same cycle → neither word reaches ID; count=0.
- Wrap: `newPC`=32'hFFFF_FFFC → next fetch at 0; the entry's `nextPC`=0.
